// File: rtl/cfg_seq_pkg.sv
// cfg_seq_pkg: shared types for the configuration sequencer.
//   seq_state_t  - sequencer FSM states
//   entry_kind_t - decoded type of one {addr, data} table entry
//   MARK_ADDR8 / END_DATA8 - marker bytes used when writing the 8/8-bit
//     table literals. At any width, all-ones addr marks a control entry,
//     and all-ones addr with all-ones data marks END.
package cfg_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SEND, S_WAIT_DLY, S_FIN
  } seq_state_t;

  typedef enum logic [1:0] {
    ENT_WRITE, ENT_DELAY, ENT_END
  } entry_kind_t;

  localparam logic [7:0] MARK_ADDR8 = 8'hFF;
  localparam logic [7:0] END_DATA8  = 8'hFF;

  // Callers pass &addr / &data so decode is width-independent.
  function automatic entry_kind_t classify(input logic addr_ones, input logic data_ones);
    if (!addr_ones) return ENT_WRITE;
    return data_ones ? ENT_END : ENT_DELAY;
  endfunction

endpackage

// File: rtl/cfg_table.sv
// cfg_table: N_PROFILES x DEPTH configuration ROM, registered 1-cycle read.
//   i_clk, i_rstn    - clock, async active-low reset
//   i_rd_en          - load o_entry from (i_profile, i_idx)
//   i_profile, i_idx - read address
//   o_entry          - {addr, data}, held while i_rd_en is low
// Profile 0 is the OV7670 RGB444 register list. Profiles 1-3 are short
// bring-up sequences. Unlisted slots and profiles read as END.
module cfg_table import cfg_seq_pkg::*; #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 128,
  parameter int N_PROFILES = 2,
  parameter int PW         = (N_PROFILES > 1) ? $clog2(N_PROFILES) : 1,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_rd_en,
  input  logic [PW-1:0]            i_profile,
  input  logic [AW-1:0]            i_idx,
  output logic [ADDR_W+DATA_W-1:0] o_entry
);

  function automatic logic [15:0] rom16(input int p, input int i);
    logic [15:0] e;
    e = {MARK_ADDR8, END_DATA8};
    if (p < N_PROFILES) begin
      case (p)
        0: case (i)
          0:  e = 16'h1280;  // COM7: soft reset
          1:  e = 16'hFF0A;  // settle 10 ms after reset
          2:  e = 16'h1204;  // COM7: RGB output
          3:  e = 16'h1100;  // CLKRC: no prescale
          4:  e = 16'h0C00;  // COM3
          5:  e = 16'h3E00;  // COM14: no scaling
          6:  e = 16'h0400;  // COM1
          7:  e = 16'h8C02;  // RGB444: enable, xR GB
          8:  e = 16'h40D0;  // COM15: full-range RGB
          9:  e = 16'h3A04;  // TSLB
          10: e = 16'h1418;  // COM9: 4x AGC ceiling
          11: e = 16'h4FB3;  // colour matrix
          12: e = 16'h50B3;
          13: e = 16'h5100;
          14: e = 16'h523D;
          15: e = 16'h53A7;
          16: e = 16'h54E4;
          17: e = 16'h589E;  // MTXS
          18: e = 16'h3DC0;  // COM13: gamma, UV sat
          19: e = 16'h1714;  // HSTART
          20: e = 16'h1802;  // HSTOP
          21: e = 16'h3280;  // HREF
          22: e = 16'h1903;  // VSTART
          23: e = 16'h1A7B;  // VSTOP
          24: e = 16'h030A;  // VREF
          default: ;
        endcase
        1: case (i)
          0: e = 16'h1280;
          1: e = 16'hFF03;
          2: e = 16'h1180;
          default: ;
        endcase
        2: case (i)
          0: e = 16'h1280;
          1: e = 16'h1180;
          default: ;
        endcase
        3: case (i)
          0: e = 16'hFF00;
          1: e = 16'h3A04;
          2: e = 16'h40D0;
          default: ;
        endcase
        default: ;
      endcase
    end
    return e;
  endfunction

  // Stretch an 8/8 literal to ADDR_W/DATA_W, keeping markers all-ones.
  function automatic logic [ADDR_W+DATA_W-1:0] widen(input logic [15:0] e);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    if (e[15:8] == MARK_ADDR8) begin
      a = '1;
      d = (e[7:0] == END_DATA8) ? '1 : DATA_W'(e[7:0]);
    end else begin
      a = ADDR_W'(e[15:8]);
      d = DATA_W'(e[7:0]);
    end
    return {a, d};
  endfunction

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)      o_entry <= '0;
    else if (i_rd_en) o_entry <= widen(rom16(int'(i_profile), int'(i_idx)));
  end

endmodule

// File: rtl/cfg_sequencer.sv
// cfg_sequencer: plays a selected configuration table out as register
// write commands over a valid/ready port.
//   i_clk, i_rstn        - clock, async active-low reset
//   i_start, i_profile   - run request; profile is latched on acceptance
//   o_cmd_valid/i_cmd_ready, o_cmd_addr/o_cmd_data - write command
//   o_busy - not idle; o_done - 1-cycle end pulse; o_err - ran off table
// Build option: CFG_SEQ_DELAY_EN enables millisecond DELAY entries. When it
// is not defined, DELAY entries are skipped.
module cfg_sequencer import cfg_seq_pkg::*; #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 128,
  parameter int N_PROFILES   = 2,
  parameter int TICKS_PER_MS = 24000
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_start,
  input  logic [((N_PROFILES > 1) ? $clog2(N_PROFILES) : 1)-1:0] i_profile,
  output logic                         o_cmd_valid,
  input  logic                         i_cmd_ready,
  output logic [ADDR_W-1:0]            o_cmd_addr,
  output logic [DATA_W-1:0]            o_cmd_data,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err
);

  localparam int PW    = (N_PROFILES > 1) ? $clog2(N_PROFILES) : 1;
  localparam int IDX_W = $clog2(DEPTH) + 1;  // one extra bit so DEPTH is reachable
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  seq_state_t               state, state_nx;
  logic [IDX_W-1:0]         idx;
  logic [PW-1:0]            prof;
  logic [ADDR_W+DATA_W-1:0] entry;
  logic [ADDR_W-1:0]        ent_addr;
  logic [DATA_W-1:0]        ent_data;
  entry_kind_t              kind;
  logic                     at_end, hs;

  // The ROM only loads in FETCH, so entry stays valid through DECODE/SEND/WAIT.
  cfg_table #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .N_PROFILES(N_PROFILES), .PW(PW), .AW(AW)
  ) u_table (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_rd_en   (state == S_FETCH && !at_end),
    .i_profile (prof),
    .i_idx     (idx[AW-1:0]),
    .o_entry   (entry)
  );

  assign {ent_addr, ent_data} = entry;
  assign kind   = classify(&ent_addr, &ent_data);
  assign at_end = (idx == IDX_W'(DEPTH));
  assign hs     = (state == S_SEND) && o_cmd_valid && i_cmd_ready;
  assign o_busy = (state != S_IDLE);

`ifdef CFG_SEQ_DELAY_EN
  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  logic [DATA_W-1:0] ms_cnt;
  logic [TW-1:0]     tick_cnt;
  logic              tick_last, dly_last;

  assign tick_last = (tick_cnt == TW'(TICKS_PER_MS - 1));
  assign dly_last  = tick_last && (ms_cnt == ent_data - DATA_W'(1));

  // tick runs 0..TICKS_PER_MS-1 per ms. Both counters are cleared whenever
  // WAIT_DLY is not being held, so each delay starts from zero.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ms_cnt   <= '0;
      tick_cnt <= '0;
    end else if (state == S_WAIT_DLY && !dly_last) begin
      if (tick_last) begin
        tick_cnt <= '0;
        if (!(&ms_cnt)) ms_cnt <= ms_cnt + DATA_W'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end else begin
      ms_cnt   <= '0;
      tick_cnt <= '0;
    end
  end
`else
  localparam int unused_ticks = TICKS_PER_MS;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (i_start) state_nx = S_FETCH;
      S_FETCH:  state_nx = at_end ? S_FIN : S_DECODE;
      S_DECODE: begin
        case (kind)
          ENT_WRITE: state_nx = S_SEND;
          ENT_END:   state_nx = S_FIN;
          default: begin
`ifdef CFG_SEQ_DELAY_EN
            state_nx = (ent_data == '0) ? S_FETCH : S_WAIT_DLY;
`else
            state_nx = S_FETCH;
`endif
          end
        endcase
      end
      S_SEND:   if (hs) state_nx = S_FETCH;
      S_WAIT_DLY: begin
`ifdef CFG_SEQ_DELAY_EN
        if (dly_last) state_nx = S_FETCH;
`else
        state_nx = S_FETCH;
`endif
      end
      S_FIN:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // o_done is registered off FIN. The pulse lands in the IDLE cycle,
  // which is also the cycle where o_busy first reads 0.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= S_IDLE;
      idx         <= '0;
      prof        <= '0;
      o_cmd_valid <= 1'b0;
      o_cmd_addr  <= '0;
      o_cmd_data  <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state  <= state_nx;
      o_done <= (state == S_FIN);
      if (state == S_IDLE && i_start) begin
        prof  <= i_profile;
        idx   <= '0;
        o_err <= 1'b0;
      end
      if (state == S_FETCH && at_end) o_err <= 1'b1;
      if (state == S_DECODE && kind == ENT_WRITE) begin
        o_cmd_valid <= 1'b1;
        o_cmd_addr  <= ent_addr;
        o_cmd_data  <= ent_data;
      end
      // The index moves past a DELAY entry at decode time. Its value is
      // only consulted again at the next FETCH.
      if (state == S_DECODE && kind == ENT_DELAY) idx <= idx + IDX_W'(1);
      if (hs) begin
        o_cmd_valid <= 1'b0;
        idx         <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cfg_sequencer.sv
// tb_cfg_sequencer: randomized runs against an entry-cost model of the table.
// DEPTH=4 truncates profile 0 so it has no END, which exercises the error path.
module tb_cfg_sequencer;
  localparam int DEPTH = 4;
  localparam int NP    = 4;
  localparam int TPM   = 10;
`ifdef CFG_SEQ_DELAY_EN
  localparam bit DLY_EN = 1'b1;
`else
  localparam bit DLY_EN = 1'b0;
`endif

  logic       i_clk = 1'b0, i_rstn = 1'b0, i_start = 1'b0, i_cmd_ready = 1'b0;
  logic [1:0] i_profile = 2'd0;
  logic       o_cmd_valid, o_busy, o_done, o_err;
  logic [7:0] o_cmd_addr, o_cmd_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  cfg_sequencer #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .N_PROFILES(NP), .TICKS_PER_MS(TPM)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_profile(i_profile),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_cmd_addr(o_cmd_addr), .o_cmd_data(o_cmd_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  typedef struct {
    bit         is_done;
    logic [7:0] a;
    logic [7:0] d;
    int         gap;   // samples after the anchor (start or handshake)
  } ev_t;

  ev_t         exp_q[$];
  bit          exp_err;
  logic [15:0] tbl [NP][DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cost per entry: each WRITE shows valid 3 cycles after its anchor. A
  // DELAY adds 2 cycles plus N*TPM when delays are enabled. END shows done
  // 4 cycles after its anchor. Running off the table shows done 3 cycles
  // after its anchor.
  task automatic build(input int p);
    int pend;
    logic [15:0] e;
    ev_t ev;
    exp_q.delete();
    pend = 0;
    for (int i = 0; i < DEPTH; i++) begin
      e = tbl[p][i];
      if (e == 16'hFFFF) begin
        ev.is_done = 1; ev.a = 0; ev.d = 0; ev.gap = pend + 4;
        exp_q.push_back(ev);
        exp_err = 0;
        return;
      end
      if (e[15:8] == 8'hFF) begin
        pend += 2 + (DLY_EN ? int'(e[7:0]) * TPM : 0);
      end else begin
        ev.is_done = 0; ev.a = e[15:8]; ev.d = e[7:0]; ev.gap = pend + 3;
        exp_q.push_back(ev);
        pend = 0;
      end
    end
    ev.is_done = 1; ev.a = 0; ev.d = 0; ev.gap = pend + 3;
    exp_q.push_back(ev);
    exp_err = 1;
  endtask

  task automatic run(input int p, input bit stall_first, input bit do_rst);
    int t, nw, k;
    bit in_send, fin, rst_done;
    ev_t ev;
    build(p);
    i_profile   = 2'(p);
    i_start     = 1'b1;
    i_cmd_ready = 1'($urandom_range(0, 1));
    t = 0; nw = 0; k = 0; in_send = 0; fin = 0; rst_done = 0;
    while (!fin) begin
      @(negedge i_clk);
      t++;
      i_start = 1'b0;
      if (t > 3000) begin
        chk("run_timeout", 0, 1);
        fin = 1;
      end else if (o_done) begin
        if (exp_q.size() == 0) begin
          chk("extra_done", 1, 0);
        end else begin
          ev = exp_q.pop_front();
          chk("done_is_end", 32'(ev.is_done), 1);
          chk("done_gap", t, ev.gap);
          chk("busy_at_done", o_busy, 0);
          chk("err_at_done", o_err, exp_err);
          chk("leftover_cmds", exp_q.size(), 0);
        end
        fin = 1;
      end else begin
        chk("busy", o_busy, 1);
        if (t == 1 && nw == 0 && !in_send) chk("err_cleared", o_err, 0);
        if (o_cmd_valid && !in_send) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_cmd", 1, 0);
            fin = 1;
          end else begin
            in_send = 1; k = 0;
            chk("cmd_latency", t, exp_q[0].gap);
            chk("cmd_is_write", 32'(exp_q[0].is_done), 0);
          end
        end
        if (in_send && !fin) begin
          chk("valid_hold", o_cmd_valid, 1);
          chk("cmd_addr", o_cmd_addr, exp_q[0].a);
          chk("cmd_data", o_cmd_data, exp_q[0].d);
        end
        if (do_rst && in_send && nw == 1 && !fin) begin
          i_rstn = 1'b0; i_start = 1'b0; i_cmd_ready = 1'b0;
          @(negedge i_clk);
          chk("rst_valid", o_cmd_valid, 0);
          chk("rst_busy", o_busy, 0);
          chk("rst_done", o_done, 0);
          chk("rst_err", o_err, 0);
          chk("rst_addr", o_cmd_addr, 0);
          chk("rst_data", o_cmd_data, 0);
          i_rstn = 1'b1;
          repeat (8) begin
            @(negedge i_clk);
            chk("post_rst_busy", o_busy, 0);
            chk("post_rst_done", o_done, 0);
          end
          rst_done = 1;
          fin = 1;
        end else if (!fin) begin
          i_cmd_ready = (stall_first && nw == 0 && in_send && k < 5) ? 1'b0
                        : ($urandom_range(0, 3) != 0);
          i_start     = ($urandom_range(0, 7) == 0);
          i_profile   = 2'($urandom);
          if (in_send && i_cmd_ready) begin
            void'(exp_q.pop_front());
            nw++; in_send = 0; t = 0;
          end
          if (in_send) k++;
        end
      end
    end
    i_start = 1'b0;
    if (!rst_done) begin
      repeat (3) begin
        @(negedge i_clk);
        chk("idle_busy", o_busy, 0);
        chk("idle_done", o_done, 0);
        chk("err_sticky", o_err, exp_err);
      end
    end
  endtask

  initial begin
    tbl[0] = '{16'h1280, 16'hFF0A, 16'h1204, 16'h1100};
    tbl[1] = '{16'h1280, 16'hFF03, 16'h1180, 16'hFFFF};
    tbl[2] = '{16'h1280, 16'h1180, 16'hFFFF, 16'hFFFF};
    tbl[3] = '{16'hFF00, 16'h3A04, 16'h40D0, 16'hFFFF};

    i_rstn = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset_valid", o_cmd_valid, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_err", o_err, 0);
    chk("reset_addr", o_cmd_addr, 0);
    chk("reset_data", o_cmd_data, 0);
    i_rstn = 1'b1;
    @(negedge i_clk);

    run(2, 0, 0);   // two writes then END
    run(1, 0, 0);   // write, 3 ms delay, write
    run(3, 0, 0);   // zero-length delay first
    run(0, 0, 0);   // no END within DEPTH -> err
    run(2, 1, 0);   // 5-cycle stall on first command; err clears
    run(1, 0, 1);   // reset during second command
    for (int r = 0; r < 18; r++)
      run($urandom_range(0, 3), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfg_sequencer.md
CFG_SEQUENCER -- requirements
Module: cfg_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, register-address width of each table entry.
REQ-002 Parameter DATA_W, default 8, register-data width of each table entry.
REQ-003 Parameter DEPTH, default 128, maximum number of entries per profile.
REQ-004 Parameter N_PROFILES, default 2, number of selectable configuration tables; must be at least 1.
REQ-005 Parameter TICKS_PER_MS, default 24000, number of i_clk cycles in 1 ms.
REQ-006 i_clk  in  1  sole clock; all logic is on the rising edge.
REQ-007 i_rstn  in  1  asynchronous, active-low reset.
REQ-008 i_start  in  1  single-cycle request to run the selected profile.
REQ-009 i_profile  in  max(1,$clog2(N_PROFILES))  profile select, sampled only when a start is accepted.
REQ-010 o_cmd_valid  out  1  register write command is pending.
REQ-011 i_cmd_ready  in  1  downstream bus master accepts the command.
REQ-012 o_cmd_addr  out  ADDR_W  register address of the pending command.
REQ-013 o_cmd_data  out  DATA_W  register data of the pending command.
REQ-014 o_busy  out  1  a sequence is in progress.
REQ-015 o_done  out  1  one-cycle pulse when a sequence ends.
REQ-016 o_err  out  1  sticky flag: the last sequence ran out of entries before reaching END; cleared by the next accepted start.

Function
REQ-017 Each table entry is {addr, data}, ADDR_W+DATA_W bits wide.
REQ-018 Entry decoding:
  - addr all-ones and data all-ones = END.
  - addr all-ones and data of any other value = DELAY of data milliseconds.
  - any other entry = WRITE.
REQ-019 FSM states and transitions:
  - IDLE: on i_start, go to FETCH.
  - FETCH: 1-cycle table read.
  - DECODE: go to SEND, WAIT_DLY or FIN according to the entry type.
  - SEND: leave after the handshake.
  - WAIT_DLY: leave when the delay expires.
  - FIN: pulse o_done, return to IDLE.
REQ-020 i_start is accepted only in IDLE; on acceptance, latch i_profile, set the index to 0, clear o_err.
REQ-021 i_start asserted while o_busy=1 is ignored.
REQ-022 o_busy = 1 in every state except IDLE.
REQ-023 Latency: o_cmd_valid rises exactly 3 cycles after the accepted i_start cycle when entry 0 is a WRITE.
REQ-024 In SEND, o_cmd_valid, o_cmd_addr and o_cmd_data hold stable until the cycle where o_cmd_valid and i_cmd_ready are both high.
REQ-025 In the handshake cycle, increment the index; o_cmd_valid drops next cycle and the FSM enters FETCH.
REQ-026 i_cmd_ready high outside SEND has no effect.
REQ-027 DELAY of N ms holds WAIT_DLY for N*TICKS_PER_MS cycles, then goes to FETCH of the next index.
REQ-028 DELAY of 0 ms proceeds to FETCH the next cycle.
REQ-029 END goes to FIN; o_done pulses for 1 cycle, and o_busy falls in the same cycle as the pulse.
REQ-030 If the index reaches DEPTH without an END entry, go to FIN, pulse o_done and set o_err=1.
REQ-031 The index counter is $clog2(DEPTH)+1 bits so that DEPTH is detectable without wrap.
REQ-032 The delay counters (ms counter and tick counter) saturate, never wrap, and clear on leaving WAIT_DLY.

Reset
REQ-033 While i_rstn=0: FSM in IDLE, index 0; o_cmd_valid, o_busy, o_done and o_err are 0; o_cmd_addr and o_cmd_data are 0; delay counters are 0.
REQ-034 Reset asserted mid-sequence aborts immediately; no o_done pulse follows release.
REQ-035 After reset release, the block waits for a new i_start.

Configuration
REQ-036 Macro CFG_SEQ_DELAY_EN defined: DELAY entries behave per REQ-027/028.
REQ-037 Macro CFG_SEQ_DELAY_EN undefined: DELAY entries are skipped in 1 cycle (DECODE to FETCH), and no delay counters are synthesised.

Structure
REQ-038 Shared package cfg_seq_pkg holds:
  - the FSM state typedef;
  - END and DELAY marker constants, derived from ADDR_W/DATA_W;
  - the entry-type enum.
REQ-039 Sub-module cfg_table holds the N_PROFILES x DEPTH entry ROM with a registered 1-cycle read.
REQ-040 The existing OV7670 RGB444 register list is profile 0 of cfg_table.

Verification
REQ-041 Table {12_80, 11_80, FF_FF}, i_cmd_ready tied 1, start -> commands 12/80 then 11/80, one o_done pulse, o_err=0.
REQ-042 i_cmd_ready low for 5 cycles on the first command -> o_cmd_valid/addr/data stable all 5 cycles, exactly one acceptance.
REQ-043 TICKS_PER_MS=10, entry FF_03 between two writes -> gap of 30 cycles in WAIT_DLY; without CFG_SEQ_DELAY_EN the gap is 1 cycle.
REQ-044 DEPTH=4 profile with no END -> 4 writes, o_done pulse, o_err=1; the next start clears o_err.
REQ-045 i_rstn pulsed low during the 2nd command, with i_start asserted again while busy in a separate run -> immediate idle with no o_done, and the extra start is ignored.
REQ-046 i_profile=1 at start, changed to 0 mid-run -> all commands come from profile 1.
